// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG_W-bit lookahead segment
// resolved per stage, segment carry and running group P/G registered between stages.

module cla_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             p_seg,
  output logic             g_seg,
  output logic             co,
  output logic             c_top
);
  localparam int NGRP = (SEG_W + 3) / 4;
  localparam int PW   = 4 * NGRP;

  logic [PW-1:0]   pw, gw, cw;
  logic [NGRP-1:0] gp, gg;
  logic [NGRP:0]   cg;

  // Pad to whole 4-bit groups with p=1/g=0 so padding never alters group P/G.
  always_comb begin
    pw = '1;
    gw = '0;
    pw[SEG_W-1:0] = a ^ b;
    gw[SEG_W-1:0] = a & b;
    gp = '1;
    gg = '0;
    cg = '0;
    cw = '0;
    p_seg = 1'b1;
    g_seg = 1'b0;
    for (int j = 0; j < NGRP; j++) begin
      for (int t = 0; t < 4; t++) begin
        gg[j] = gw[4*j+t] | (pw[4*j+t] & gg[j]);
        gp[j] = gp[j] & pw[4*j+t];
      end
    end
    cg[0] = ci;
    for (int j = 0; j < NGRP; j++) begin
      cg[j+1] = gg[j] | (gp[j] & cg[j]);
      cw[4*j] = cg[j];
      for (int t = 0; t < 3; t++)
        cw[4*j+t+1] = gw[4*j+t] | (pw[4*j+t] & cw[4*j+t]);
      p_seg = p_seg & gp[j];
      g_seg = gg[j] | (gp[j] & g_seg);
    end
    s     = pw[SEG_W-1:0] ^ cw[SEG_W-1:0];
    co    = cg[NGRP];
    c_top = cw[SEG_W-1];
  end
endmodule

module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             p_all,
  output logic             g_all
);
  localparam int NSEG = WIDTH / SEG_W;

  // Rank k < NSEG feeds segment k; rank NSEG is the output register.
  logic [NSEG:0]                  vld_pipe;
  logic [NSEG:0][WIDTH-1:0]       w_q;
  logic [NSEG-1:0][WIDTH-1:0]     b_q;
  logic [NSEG:0]                  c_q, p_q, g_q;
  logic                           ovf_q;

  logic [NSEG-1:0][SEG_W-1:0]     s_nx;
  logic [NSEG-1:0]                c_nx, ps_nx, gs_nx, ct_nx;
  logic                           adv;

  assign adv      = ~vld_pipe[NSEG] | out_ready;
  assign in_ready = adv;

  generate
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
      cla_seg #(.SEG_W(SEG_W)) u_seg (
        .a     (w_q[k][k*SEG_W +: SEG_W]),
        .b     (b_q[k][k*SEG_W +: SEG_W]),
        .ci    (c_q[k]),
        .s     (s_nx[k]),
        .p_seg (ps_nx[k]),
        .g_seg (gs_nx[k]),
        .co    (c_nx[k]),
        .c_top (ct_nx[k])
      );
    end
  endgenerate

  // Operand bits of already-resolved segments and inner carry-into-MSB taps are dead.
  logic unused_bits;
  assign unused_bits = ^{b_q, ct_nx};

  // w_q carries resolved sum bits below the current segment and raw A bits above it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      w_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      p_q      <= '0;
      g_q      <= '0;
      ovf_q    <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[NSEG-1:0], in_valid};
      w_q[0]   <= A;
      b_q[0]   <= sub ? ~B : B;
      c_q[0]   <= sub | cin;
      p_q[0]   <= 1'b1;
      g_q[0]   <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        w_q[k+1]                   <= w_q[k];
        w_q[k+1][k*SEG_W +: SEG_W] <= s_nx[k];
        c_q[k+1]                   <= c_nx[k];
        p_q[k+1]                   <= p_q[k] & ps_nx[k];
        g_q[k+1]                   <= gs_nx[k] | (g_q[k] & ps_nx[k]);
      end
      for (int k = 1; k < NSEG; k++)
        b_q[k] <= b_q[k-1];
      ovf_q <= ct_nx[NSEG-1] ^ c_nx[NSEG-1];
    end
  end

  assign out_valid = vld_pipe[NSEG];
  assign S         = w_q[NSEG];
  assign cout      = c_q[NSEG];
  assign ovf       = ovf_q;
  assign p_all     = p_q[NSEG];
  assign g_all     = g_q[NSEG];
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and streaming checks of cla_pipe_adder at 32/8, 16/4 and 8/8,
// all three instances fed the same inputs and selected for observation by sel.
module tb_cla_pipe_adder;
  logic        clk, rst_n;
  logic        in_valid, out_ready, cin, sub;
  logic [31:0] A, B;
  logic [1:0]  sel;

  logic        r32, v32, c32, ov32, p32, g32;
  logic [31:0] S32;
  logic        r16, v16, c16, ov16, p16, g16;
  logic [15:0] S16;
  logic        r8, v8, c8, ov8, p8, g8;
  logic [7:0]  S8;

  logic        o_rdy, o_vld, o_c, o_o, o_p, o_g;
  logic [31:0] o_S;

  int chk_cnt = 0;
  int pass_cnt = 0;

  cla_pipe_adder #(.WIDTH(32), .SEG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32), .A(A), .B(B),
    .cin(cin), .sub(sub), .out_valid(v32), .out_ready(out_ready), .S(S32),
    .cout(c32), .ovf(ov32), .p_all(p32), .g_all(g32));

  cla_pipe_adder #(.WIDTH(16), .SEG_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r16), .A(A[15:0]), .B(B[15:0]),
    .cin(cin), .sub(sub), .out_valid(v16), .out_ready(out_ready), .S(S16),
    .cout(c16), .ovf(ov16), .p_all(p16), .g_all(g16));

  cla_pipe_adder #(.WIDTH(8), .SEG_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r8), .A(A[7:0]), .B(B[7:0]),
    .cin(cin), .sub(sub), .out_valid(v8), .out_ready(out_ready), .S(S8),
    .cout(c8), .ovf(ov8), .p_all(p8), .g_all(g8));

  always_comb begin
    o_rdy = r32; o_vld = v32; o_S = S32; o_c = c32; o_o = ov32; o_p = p32; o_g = g32;
    if (sel == 2'd1) begin
      o_rdy = r16; o_vld = v16; o_S = {16'h0, S16}; o_c = c16; o_o = ov16; o_p = p16; o_g = g16;
    end else if (sel == 2'd2) begin
      o_rdy = r8; o_vld = v8; o_S = {24'h0, S8}; o_c = c8; o_o = ov8; o_p = p8; o_g = g8;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Golden {ovf, cout, S} for a w-bit add/sub, from plain integer arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb, input int w);
    logic [63:0] m, lm, bp, full, part, c0;
    m    = (64'd1 << w) - 64'd1;
    lm   = (64'd1 << (w - 1)) - 64'd1;
    c0   = {63'd0, sb | ci};
    bp   = (sb ? ~{32'h0, b} : {32'h0, b}) & m;
    full = ({32'h0, a} & m) + bp + c0;
    part = ({32'h0, a} & lm) + (bp & lm) + c0;
    return {part[w-1] ^ full[w], full[w], full[31:0] & m[31:0]};
  endfunction

  task automatic test_reset();
    #13;
    chk_cnt++;
    if ({o_vld, o_S, o_c, o_o, o_p, o_g} !== 37'd0)
      $display("FAIL reset_outputs: got vld=%b S=%h c=%b o=%b p=%b g=%b, need all 0",
               o_vld, o_S, o_c, o_o, o_p, o_g);
    else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk_cnt++;
    if (o_rdy !== 1'b1) $display("FAIL reset_in_ready: got %b need 1", o_rdy);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [31:0] ta [5] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'hAAAA_AAAA, 32'h0000_0005};
    logic [31:0] tb [5] = '{32'h0000_0001, 32'h0000_0007, 32'h0000_0001, 32'h5555_5555, 32'h0000_0007};
    logic [1:0]  tcs[5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11};  // {cin, sub}
    // {S, cout, ovf, p_all, g_all}
    logic [35:0] te [5] = '{{32'h0000_0000, 4'b1001}, {32'hFFFF_FFFE, 4'b0000},
                            {32'h7FFF_FFFF, 4'b1101}, {32'h0000_0000, 4'b1010},
                            {32'hFFFF_FFFE, 4'b0000}};
    int lat;
    for (int i = 0; i < 5; i++) begin
      A = ta[i]; B = tb[i]; {cin, sub} = tcs[i];
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!o_vld && lat < 20) begin tick(); lat++; end
      chk_cnt++;
      if (lat !== 4) $display("FAIL directed_latency[%0d]: got %0d need 4", i, lat);
      else pass_cnt++;
      chk_cnt++;
      if ({o_S, o_c, o_o, o_p, o_g} !== te[i])
        $display("FAIL directed[%0d]: got S=%h c=%b o=%b p=%b g=%b need %h", i,
                 o_S, o_c, o_o, o_p, o_g, te[i]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] q[$];
    logic [33:0] e;
    int sent = 0, got = 0, first = -1, last = -1;
    A = $urandom; B = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 140 && got < 100; cyc++) begin
      if (o_vld) begin
        chk_cnt++;
        if (q.size() == 0) $display("FAIL stream_spurious: output at cycle %0d with none pending", cyc);
        else begin
          e = q.pop_front();
          if ({o_o, o_c, o_S} !== e)
            $display("FAIL stream[%0d]: got o=%b c=%b S=%h need %h", got, o_o, o_c, o_S, e);
          else pass_cnt++;
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (in_valid && o_rdy) begin
        q.push_back(model(A, B, cin, sub, 32));
        sent++;
      end
      tick();
      if (sent < 100) begin
        A = $urandom; B = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (got !== 100) $display("FAIL stream_count: got %0d need 100", got);
    else pass_cnt++;
    chk_cnt++;
    if (first !== 5) $display("FAIL stream_first_cycle: got %0d need 5", first);
    else pass_cnt++;
    chk_cnt++;
    if (last - first !== 99) $display("FAIL stream_rate: span %0d need 99", last - first);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    localparam int N = 60;
    logic [33:0] q[$];
    logic [33:0] e, hold;
    logic stall = 1'b0, xfer;
    int sent = 0, got = 0;
    A = $urandom; B = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    hold = '0;
    for (int cyc = 0; cyc < 2000 && got < N; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk_cnt++;
      if (o_rdy !== ~(o_vld & ~out_ready))
        $display("FAIL bp_in_ready: got %b with vld=%b ordy=%b", o_rdy, o_vld, out_ready);
      else pass_cnt++;
      if (stall) begin
        chk_cnt++;
        if (!o_vld || {o_o, o_c, o_S} !== hold)
          $display("FAIL bp_stable: got vld=%b %h need 1 %h", o_vld, {o_o, o_c, o_S}, hold);
        else pass_cnt++;
      end
      stall = o_vld & ~out_ready;
      hold  = {o_o, o_c, o_S};
      if (o_vld && out_ready) begin
        chk_cnt++;
        if (q.size() == 0) $display("FAIL bp_spurious: output with none pending");
        else begin
          e = q.pop_front();
          if ({o_o, o_c, o_S} !== e) $display("FAIL bp_order[%0d]: got %h need %h", got, {o_o, o_c, o_S}, e);
          else pass_cnt++;
        end
        got++;
      end
      xfer = in_valid & o_rdy;
      if (xfer) begin
        q.push_back(model(A, B, cin, sub, 32));
        sent++;
      end
      tick();
      if (xfer) begin
        if (sent < N) begin
          A = $urandom; B = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        end else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (got !== N || q.size() != 0) $display("FAIL bp_count: got %0d need %0d, %0d left", got, N, q.size());
    else pass_cnt++;
    out_ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset_flight(input logic [1:0] s, input int w, input int nseg);
    logic [31:0] va[3] = '{32'h1234_5678, 32'h0F0F_00FF, 32'h8765_4321};
    logic [33:0] e;
    int lat;
    sel = s;
    out_ready = 1'b0; in_valid = 1'b1; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = va[i]; B = ~va[i] + 32'd3; sub = (i == 1);
      tick();
    end
    in_valid = 1'b0;
    lat = 0;
    while (!o_vld && lat < 20) begin tick(); lat++; end
    e = model(32'h1234_5678, ~32'h1234_5678 + 32'd3, 1'b0, 1'b0, w);
    chk_cnt++;
    if (!o_vld || o_S !== e[31:0]) $display("FAIL flight_pre[w%0d]: got vld=%b S=%h need 1 %h", w, o_vld, o_S, e[31:0]);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({o_vld, o_S, o_c, o_o, o_p, o_g} !== 37'd0)
      $display("FAIL flight_async_reset[w%0d]: got vld=%b S=%h c=%b o=%b p=%b g=%b", w,
               o_vld, o_S, o_c, o_o, o_p, o_g);
    else pass_cnt++;
    #2 rst_n = 1'b1;
    A = 32'hCAFE_F00D; B = 32'h0000_1111; cin = 1'b1; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!o_vld && lat < 20) begin tick(); lat++; end
    e = model(32'hCAFE_F00D, 32'h0000_1111, 1'b1, 1'b0, w);
    chk_cnt++;
    if (lat !== nseg) $display("FAIL flight_latency[w%0d]: got %0d need %0d", w, lat, nseg);
    else pass_cnt++;
    chk_cnt++;
    if ({o_o, o_c, o_S} !== e) $display("FAIL flight_result[w%0d]: got %h need %h", w, {o_o, o_c, o_S}, e);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; cin = 1'b0; sub = 1'b0; sel = 2'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_flight(2'd0, 32, 4);
    test_reset_flight(2'd1, 16, 4);
    test_reset_flight(2'd2, 8, 1);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor, successor to the fixed 16-bit two-level CLA. The operand is split into SEG_W-bit segments, each resolved by a combinational carry-lookahead segment in its own pipeline stage, with the segment carry registered between stages. It gives full-word add/sub at one result per cycle, with a valid/ready handshake, for wide datapaths where a single-cycle CLA misses timing.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of SEG_W, ≥ SEG_W.
- SEG_W, 8: bits resolved per stage; NSEG = WIDTH/SEG_W = pipeline depth.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  stage 1 can accept.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cin  input  1  carry in (ignored when sub=1).
- sub  input  1  1: A−B (B inverted, carry-in forced 1).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts.
- S  output  WIDTH  sum/difference.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  signed overflow: carry into MSB XOR cout.
- p_all  output  1  word-level group propagate (AND of segment P).
- g_all  output  1  word-level group generate (lookahead combine of segment G, MSB segment dominant).

## Operation
- Stage k (k = 1..NSEG) holds: valid bit, sum bits of segments 1..k-1 (already resolved), unresolved operand bits of segments k..NSEG, registered carry into segment k, running P/G, sub flag.
- On accept into stage 1: B' = sub ? ~B : B; c0 = sub ? 1 : cin. Stage 1 resolves segment 1 (bits SEG_W:1) of A + B' + c0.
- Each segment: bit p = a^b, g = a&b; 4-bit lookahead groups combined into segment P/G; sum = p ^ carry. Segment carry-out = G | (P & c_in).
- Running group: P_acc ← P_acc & P_seg; G_acc ← G_seg | (G_acc & P_seg).
- Final stage outputs: S, cout = last segment carry-out, ovf = carry into bit WIDTH XOR cout, p_all = P_acc, g_all = G_acc.
- Results leave in acceptance order; no reordering, no dropping.
- Arithmetic is modulo 2^WIDTH; cout carries the 2^WIDTH bit.

## Timing
- Reset (rst_n low, async): all stage valid bits 0, out_valid 0, S 0, cout 0, ovf 0, p_all 0, g_all 0. Data registers may also clear. After release, in_ready = 1 on the first edge.
- Latency: operand accepted at edge n → out_valid at edge n+NSEG when no stall.
- Throughput: one result per cycle while out_ready = 1.
- Advance: adv = ~out_valid | out_ready. All stages shift together when adv = 1 and hold when adv = 0. in_ready = adv (combinational from out_ready, no combinational path from in_valid).
- Bubbles: stage valid = 0 entries shift like data. A bubble is not collapsed while stalled.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Output registers stay stable while out_valid = 1 & out_ready = 0.
- Simultaneous accept and emit in the same cycle when full: legal and lossless.
- Reset mid-operation discards every in-flight result. No partial output.

## Test plan
- WIDTH=32, SEG_W=8: A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0 → after 4 cycles S=0x00000000, cout=1, ovf=0, p_all=0, g_all=1.
- Sub: A=0x00000005, B=0x00000007, sub=1 → S=0xFFFFFFFE, cout=0, ovf=0. A=0x80000000, B=1, sub=1 → S=0x7FFFFFFF, ovf=1, cout=1.
- Propagate chain: A=0xAAAAAAAA, B=0x55555555, cin=1 → S=0, cout=1, p_all=1, g_all=0. The carry must ripple across all 4 stage registers.
- Back-to-back streaming of 100 random pairs with out_ready=1 → one result/cycle, 4-cycle latency, matches a golden A±B model including cout/ovf.
- Backpressure: random out_ready (50%) with continuous in_valid → no loss or duplication, order preserved, S stable while stalled, in_ready=0 exactly when out_valid & ~out_ready.
- Reset asserted asynchronously with 3 results in flight → out_valid and all outputs 0 immediately. After release, the first new operand emerges at NSEG cycles with no stale data. Repeat with WIDTH=16, SEG_W=4 and WIDTH=SEG_W=8 (single stage).
